decode_stage_sb: RTL and testbench
==================================

Name: decode_stage_sb

Overview:
- Parametrised successor to the ID stage.
- Decodes the 32-bit instruction and reads the scalar and vector register banks.
- Tracks RAW hazards with a per-register scoreboard and stalls fetch while a source is pending.
- Holds the ID/EX pipeline register behind a valid/ready handshake, with flush support.

Parameters:
- DATA_W, 24, scalar word width; also the vector lane width.
- LANES, 6, lanes per vector register; vector width = DATA_W*LANES.
- REG_IDX_W, 4, register index width; NREGS = 2**REG_IDX_W.
- IMM_W, 18, immediate field width; sign-extended to DATA_W.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kills the instruction held in the ID/EX register.
- in_valid  in  1  fetch presents inst/pc.
- in_ready  out  1  decode accepts inst/pc this cycle.
- inst  in  32  opType[31:30], opCode[29:26], Rc[25:22], Ra[21:18], Rb[17:14], imm[IMM_W-1:0].
- pc  in  DATA_W  pc of inst.
- wb_we_s  in  1  scalar writeback enable.
- wb_we_v  in  1  vector writeback enable.
- wb_rd  in  REG_IDX_W  writeback destination index.
- wb_data_s  in  DATA_W  scalar writeback data.
- wb_data_v  in  DATA_W*LANES  vector writeback data.
- out_valid  out  1  ID/EX register holds a live instruction.
- out_ready  in  1  execute accepts the instruction.
- out_ctrl  out  16  {modeSel, regWriteV, opType, opCode, immSrc, branchFlag, memWrite, memToReg, regWrite, aluControl}; produced by the existing control unit, registered here.
- out_ra, out_rb, out_rc  out  REG_IDX_W each  source/destination indices.
- out_rd1, out_rd2, out_rd3  out  DATA_W each  scalar read data for Ra, Rb, Rc.
- out_rdv1, out_rdv2, out_rdv3  out  DATA_W*LANES each  vector read data for Ra, Rb, Rc.
- out_imm  out  DATA_W  sign-extended immediate.
- out_pc  out  DATA_W  registered pc.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=0, async): both register banks, both scoreboards, the ID/EX register, out_valid and stall_cnt all clear to 0.
- Register banks: NREGS x DATA_W (scalar) and NREGS x DATA_W*LANES (vector). Three combinational reads (Ra, Rb, Rc), one synchronous write port each.
- Scoreboards: sb_s[NREGS], sb_v[NREGS]; bit = 1 means a write to that register is in flight.
- Hazard:
  - Checked against sb_v when decoded modeSel=1, against sb_s otherwise.
  - Sources checked: Ra, Rb, and Rc when memWrite=1 (store reads Rc).
  - hazard = in_valid & any checked bit set.
- Handshake:
  - in_ready = !hazard & (!out_valid | out_ready).
  - Accept = in_valid & in_ready; on accept the ID/EX register loads and out_valid <= 1.
  - If out_valid & out_ready & !accept, then out_valid <= 0.
  - While out_valid=1 & out_ready=0, all outputs hold stable.
- Scoreboard set on accept: sb_s[Rc] <= 1 if regWrite; sb_v[Rc] <= 1 if regWriteV.
- Scoreboard clear on writeback: wb_we_s clears sb_s[wb_rd]; wb_we_v clears sb_v[wb_rd].
- Same register set and cleared in one cycle: set wins (the new producer owns it).
- Flush:
  - Synchronous; out_valid <= 0 and in_ready is forced 0 for that cycle.
  - If the killed instruction set a scoreboard bit, that bit is cleared, unless the same cycle's writeback targets it, in which case it is also clear.
  - Flush has priority over accept.
- stall_cnt increments when in_valid & hazard; saturates at all-ones; no wrap.
- Latency: one cycle from accept to out_valid.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - A writeback in the same cycle to a pending source counts as resolved, so no stall.
  - Read data for a matching index comes from wb_data_s / wb_data_v, selected per source.
- Undefined:
  - The hazard persists that cycle.
  - The instruction issues the following cycle, reading the bank; one extra stall cycle per such hazard.

Test Plan:
- Reset mid-operation (out_valid=1, sb_s[3]=1), rst=0 -> immediately out_valid=0, sb_s=0, stall_cnt=0, all outputs 0.
- Back-to-back independent adds R1=R2+R3, R4=R5+R6, out_ready=1 -> one issue per cycle, out_valid continuous, stall_cnt=0.
- Producer R1 (scalar), consumer R2=R1+R3, writeback of R1 four cycles later:
  - Bypass defined: consumer issues in the writeback cycle with rd1=wb_data_s, stall_cnt=3.
  - Bypass undefined: consumer issues in the cycle after, stall_cnt=4.
- Vector producer V2, scalar consumer reading R2 -> no stall; scoreboards are independent.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs constant; out_ready=1 -> held instruction leaves and the next is accepted in the same cycle.
- Flush while ID/EX holds a writer to R7 -> out_valid=0 next cycle, sb_s[7]=0; a following reader of R7 issues without stall.

Source files
------------

// File: rtl/decode_stage_sb.sv
// Instruction decode stage with scalar and vector register banks, per-register RAW scoreboards, and a valid/ready ID/EX register.
// Optional macro WB_BYPASS_EN: a same-cycle writeback resolves a pending source and forwards its data.
module decode_stage_sb #(
  parameter int DATA_W    = 24,
  parameter int LANES     = 6,
  parameter int REG_IDX_W = 4,
  parameter int IMM_W     = 18,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  input  logic [DATA_W-1:0]         pc,
  input  logic                      wb_we_s,
  input  logic                      wb_we_v,
  input  logic [REG_IDX_W-1:0]      wb_rd,
  input  logic [DATA_W-1:0]         wb_data_s,
  input  logic [DATA_W*LANES-1:0]   wb_data_v,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_ctrl,
  output logic [REG_IDX_W-1:0]      out_ra,
  output logic [REG_IDX_W-1:0]      out_rb,
  output logic [REG_IDX_W-1:0]      out_rc,
  output logic [DATA_W-1:0]         out_rd1,
  output logic [DATA_W-1:0]         out_rd2,
  output logic [DATA_W-1:0]         out_rd3,
  output logic [DATA_W*LANES-1:0]   out_rdv1,
  output logic [DATA_W*LANES-1:0]   out_rdv2,
  output logic [DATA_W*LANES-1:0]   out_rdv3,
  output logic [DATA_W-1:0]         out_imm,
  output logic [DATA_W-1:0]         out_pc,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int NREGS = 2**REG_IDX_W;
  localparam int VEC_W = DATA_W*LANES;

  logic [1:0]           op_type;
  logic [3:0]           op_code;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic [DATA_W-1:0]    imm_ext;
  logic                 mode_sel, reg_write_v, imm_src, branch_flag;
  logic                 mem_write, mem_to_reg, reg_write;
  logic [2:0]           alu_ctrl;
  logic [15:0]          ctrl;

  logic [DATA_W-1:0]    bank_s_q [NREGS];
  logic [VEC_W-1:0]     bank_v_q [NREGS];
  logic [NREGS-1:0]     sb_s_q, sb_s_d, sb_v_q, sb_v_d;
  logic [NREGS-1:0]     wb_oh, pend;
  logic                 hazard, accept;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  logic [REG_IDX_W-1:0] src_idx [3];
  logic [DATA_W-1:0]    rd_s [3];
  logic [VEC_W-1:0]     rd_v [3];

  logic [15:0]          ctrl_q;
  logic [REG_IDX_W-1:0] ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]    rd_s_q [3];
  logic [VEC_W-1:0]     rd_v_q [3];
  logic [DATA_W-1:0]    imm_q, pc_q;

  // Rb and the upper immediate bits share inst[17:14]
  assign op_type = inst[31:30];
  assign op_code = inst[29:26];
  assign rc      = inst[22 +: REG_IDX_W];
  assign ra      = inst[18 +: REG_IDX_W];
  assign rb      = inst[14 +: REG_IDX_W];
  assign imm_ext = {{(DATA_W-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};

  always_comb begin
    mode_sel    = 1'b0;
    reg_write_v = 1'b0;
    imm_src     = 1'b0;
    branch_flag = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_ctrl    = 3'b000;
    case (op_type)
      2'b00: begin
        reg_write = 1'b1;
        imm_src   = op_code[3];
        alu_ctrl  = op_code[2:0];
      end
      2'b01: begin
        imm_src = 1'b1;
        if (op_code[0]) begin
          mem_write = 1'b1;
        end else begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
      end
      2'b10: begin
        mode_sel    = 1'b1;
        reg_write_v = 1'b1;
        alu_ctrl    = op_code[2:0];
      end
      default: begin
        branch_flag = 1'b1;
        imm_src     = 1'b1;
        alu_ctrl    = 3'b001;
      end
    endcase
  end

  assign ctrl = {mode_sel, reg_write_v, op_type, op_code, imm_src, branch_flag,
                 mem_write, mem_to_reg, reg_write, alu_ctrl};

  always_comb begin
    wb_oh        = '0;
    wb_oh[wb_rd] = 1'b1;
  end

  always_comb begin
    pend = mode_sel ? sb_v_q : sb_s_q;
`ifdef WB_BYPASS_EN
    if (mode_sel ? wb_we_v : wb_we_s) pend = pend & ~wb_oh;
`endif
  end

  // Stores read Rc, so it joins the hazard check only for them
  assign hazard   = in_valid & (pend[ra] | pend[rb] | (mem_write & pend[rc]));
  assign in_ready = ~flush & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign src_idx[0] = ra;
  assign src_idx[1] = rb;
  assign src_idx[2] = rc;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_s[k] = bank_s_q[src_idx[k]];
      rd_v[k] = bank_v_q[src_idx[k]];
`ifdef WB_BYPASS_EN
      if (wb_we_s && wb_rd == src_idx[k]) rd_s[k] = wb_data_s;
      if (wb_we_v && wb_rd == src_idx[k]) rd_v[k] = wb_data_v;
`endif
    end
  end

  // Order matters: writeback clear, then flush undo, then accept set (set wins)
  always_comb begin
    sb_s_d = sb_s_q;
    sb_v_d = sb_v_q;
    if (wb_we_s) sb_s_d[wb_rd] = 1'b0;
    if (wb_we_v) sb_v_d[wb_rd] = 1'b0;
    if (flush && out_valid_q) begin
      if (ctrl_q[3])  sb_s_d[rc_q] = 1'b0;
      if (ctrl_q[14]) sb_v_d[rc_q] = 1'b0;
    end
    if (accept) begin
      if (reg_write)   sb_s_d[rc] = 1'b1;
      if (reg_write_v) sb_v_d[rc] = 1'b1;
    end
  end

  always_comb begin
    if (flush)            out_valid_d = 1'b0;
    else if (accept)      out_valid_d = 1'b1;
    else if (out_ready)   out_valid_d = 1'b0;
    else                  out_valid_d = out_valid_q;
    stall_d = stall_q;
    if (hazard && stall_q != '1) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bank_s_q[i] <= '0;
        bank_v_q[i] <= '0;
      end
      sb_s_q      <= '0;
      sb_v_q      <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (wb_we_s) bank_s_q[wb_rd] <= wb_data_s;
      if (wb_we_v) bank_v_q[wb_rd] <= wb_data_v;
      sb_s_q      <= sb_s_d;
      sb_v_q      <= sb_v_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        rd_s_q[k] <= '0;
        rd_v_q[k] <= '0;
      end
    end else if (accept) begin
      ctrl_q <= ctrl;
      ra_q   <= ra;
      rb_q   <= rb;
      rc_q   <= rc;
      imm_q  <= imm_ext;
      pc_q   <= pc;
      for (int k = 0; k < 3; k++) begin
        rd_s_q[k] <= rd_s[k];
        rd_v_q[k] <= rd_v[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_ra    = ra_q;
  assign out_rb    = rb_q;
  assign out_rc    = rc_q;
  assign out_rd1   = rd_s_q[0];
  assign out_rd2   = rd_s_q[1];
  assign out_rd3   = rd_s_q[2];
  assign out_rdv1  = rd_v_q[0];
  assign out_rdv2  = rd_v_q[1];
  assign out_rdv3  = rd_v_q[2];
  assign out_imm   = imm_q;
  assign out_pc    = pc_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Self-checking bench for decode_stage_sb: decode table, hand-written hazard/handshake
// sequences, and a random run against a transaction-level reference model.
module tb_decode_stage_sb;

  localparam int NR = 16;
  localparam int VW = 144;
  localparam int PW = 580;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic           in_ready, out_valid;
  logic [31:0]    inst = '0;
  logic [23:0]    pc = '0;
  logic           wb_we_s = 1'b0, wb_we_v = 1'b0;
  logic [3:0]     wb_rd = '0;
  logic [23:0]    wb_data_s = '0;
  logic [VW-1:0]  wb_data_v = '0;
  logic [15:0]    out_ctrl;
  logic [3:0]     out_ra, out_rb, out_rc;
  logic [23:0]    out_rd1, out_rd2, out_rd3, out_imm, out_pc;
  logic [VW-1:0]  out_rdv1, out_rdv2, out_rdv3;
  logic [15:0]    stall_cnt;
  logic [PW-1:0]  dut_pay;

  int nchk = 0;
  int nerr = 0;

  decode_stage_sb dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .wb_we_s(wb_we_s), .wb_we_v(wb_we_v), .wb_rd(wb_rd),
    .wb_data_s(wb_data_s), .wb_data_v(wb_data_v), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_ra(out_ra), .out_rb(out_rb),
    .out_rc(out_rc), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_rd3(out_rd3),
    .out_rdv1(out_rdv1), .out_rdv2(out_rdv2), .out_rdv3(out_rdv3),
    .out_imm(out_imm), .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign dut_pay = {out_ctrl, out_ra, out_rb, out_rc, out_rd1, out_rd2, out_rd3,
                    out_rdv1, out_rdv2, out_rdv3, out_imm, out_pc};

  // ---------------- reference model ----------------
  logic [23:0]   m_bank_s [NR];
  logic [VW-1:0] m_bank_v [NR];
  bit [NR-1:0]   m_pend_s, m_pend_v;
  bit            m_valid, m_haz, m_rdy, seen_rdy;
  logic [PW-1:0] m_pay;
  logic [15:0]   m_ctrl;
  logic [3:0]    m_rc;
  int            m_stall;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] c,
                                     input logic [3:0] rc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [13:0] lo);
    return {t, c, rc, ra, rb, lo};
  endfunction

  function automatic logic [15:0] dec_ctrl(input logic [31:0] i);
    logic [1:0] t;
    logic [3:0] c;
    bit mode, rwv, isrc, br, mw, m2r, rw;
    logic [2:0] alu;
    t = i[31:30]; c = i[29:26];
    mode = 0; rwv = 0; isrc = 0; br = 0; mw = 0; m2r = 0; rw = 0; alu = 3'b000;
    case (t)
      2'd0: begin rw = 1; isrc = c[3]; alu = c[2:0]; end
      2'd1: begin isrc = 1; if (c[0]) mw = 1; else begin m2r = 1; rw = 1; end end
      2'd2: begin mode = 1; rwv = 1; alu = c[2:0]; end
      default: begin br = 1; isrc = 1; alu = 3'b001; end
    endcase
    return {mode, rwv, t, c, isrc, br, mw, m2r, rw, alu};
  endfunction

  function automatic bit pending(input bit vec, input logic [3:0] idx);
    bit p;
    p = vec ? m_pend_v[idx] : m_pend_s[idx];
`ifdef WB_BYPASS_EN
    if (vec ? (wb_we_v && wb_rd == idx) : (wb_we_s && wb_rd == idx)) p = 0;
`endif
    return p;
  endfunction

  function automatic logic [23:0] rs(input logic [3:0] idx);
    logic [23:0] v;
    v = m_bank_s[idx];
`ifdef WB_BYPASS_EN
    if (wb_we_s && wb_rd == idx) v = wb_data_s;
`endif
    return v;
  endfunction

  function automatic logic [VW-1:0] rv(input logic [3:0] idx);
    logic [VW-1:0] v;
    v = m_bank_v[idx];
`ifdef WB_BYPASS_EN
    if (wb_we_v && wb_rd == idx) v = wb_data_v;
`endif
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin
      m_bank_s[i] = '0;
      m_bank_v[i] = '0;
    end
    m_pend_s = '0; m_pend_v = '0; m_valid = 0; m_pay = '0;
    m_ctrl = '0; m_rc = '0; m_stall = 0;
  endtask

  task automatic m_eval();
    logic [15:0] c;
    bit busy;
    c = dec_ctrl(inst);
    busy = pending(c[15], inst[21:18]) || pending(c[15], inst[17:14]) ||
           (c[5] && pending(c[15], inst[25:22]));
    m_haz = in_valid && busy;
    m_rdy = !flush && !m_haz && (!m_valid || out_ready);
  endtask

  task automatic m_clock();
    logic [15:0] c;
    logic [3:0] a, b, d;
    bit acc;
    c = dec_ctrl(inst);
    a = inst[21:18]; b = inst[17:14]; d = inst[25:22];
    acc = in_valid && m_rdy;
    if (m_haz && m_stall < 65535) m_stall++;
    if (wb_we_s) m_pend_s[wb_rd] = 0;
    if (wb_we_v) m_pend_v[wb_rd] = 0;
    if (flush && m_valid) begin
      if (m_ctrl[3])  m_pend_s[m_rc] = 0;
      if (m_ctrl[14]) m_pend_v[m_rc] = 0;
    end
    if (acc) begin
      m_pay = {c, a, b, d, rs(a), rs(b), rs(d), rv(a), rv(b), rv(d),
               {{6{inst[17]}}, inst[17:0]}, pc};
      m_ctrl = c;
      m_rc = d;
      if (c[3])  m_pend_s[d] = 1;
      if (c[14]) m_pend_v[d] = 1;
    end
    if (flush)          m_valid = 0;
    else if (acc)       m_valid = 1;
    else if (out_ready) m_valid = 0;
    if (wb_we_s) m_bank_s[wb_rd] = wb_data_s;
    if (wb_we_v) m_bank_v[wb_rd] = wb_data_v;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] i, input logic [23:0] p);
    in_valid = v; inst = i; pc = p;
  endtask

  task automatic set_wb(input bit s, input bit v, input logic [3:0] rd,
                        input logic [23:0] ds, input logic [VW-1:0] dv);
    wb_we_s = s; wb_we_v = v; wb_rd = rd; wb_data_s = ds; wb_data_v = dv;
  endtask

  task automatic tick();
    @(negedge clk);
    m_eval();
    seen_rdy = in_ready;
    chk("in_ready", PW'(in_ready), PW'(m_rdy));
    @(posedge clk);
    m_clock();
    #1;
    chk("out_valid", PW'(out_valid), PW'(m_valid));
    chk("stall_cnt", PW'(stall_cnt), PW'(m_stall[15:0]));
    chk("payload", dut_pay, m_pay);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock
  task automatic reset_dut();
    set_in(0, '0, '0);
    set_wb(0, 0, '0, '0, '0);
    flush = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_stall_cnt", PW'(stall_cnt), PW'(0));
    chk("rst_outputs", dut_pay, PW'(0));
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [15:0] ctrl;
    logic [23:0] imm;
  } vec_t;

  vec_t tbl[6];
  int acc_t;
  logic [159:0] rnd_v;

  initial begin
    tbl[0] = '{mk(2'd0, 4'b0010, 4'd12, 4'd0, 4'h0, 14'h0005), 16'h020A, 24'h000005};
    tbl[1] = '{mk(2'd0, 4'b1101, 4'd13, 4'd0, 4'hF, 14'h3FFF), 16'h0D8D, 24'hFFFFFF};
    tbl[2] = '{mk(2'd1, 4'b0000, 4'd14, 4'd0, 4'h8, 14'h0000), 16'h1098, 24'hFE0000};
    tbl[3] = '{mk(2'd1, 4'b0001, 4'd0,  4'd0, 4'h7, 14'h3FFF), 16'h11A0, 24'h01FFFF};
    tbl[4] = '{mk(2'd2, 4'b0011, 4'd11, 4'd0, 4'h0, 14'h0010), 16'hE303, 24'h000010};
    tbl[5] = '{mk(2'd3, 4'b0110, 4'd0,  4'd0, 4'hF, 14'h3FF0), 16'h36C1, 24'hFFFFF0};

    reset_dut();

    // decode table
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      set_in(1, tbl[i].inst, 24'h10 + 24'(i));
      tick();
      chk("tbl_valid", PW'(out_valid), PW'(1));
      chk("tbl_ctrl", PW'(out_ctrl), PW'(tbl[i].ctrl));
      chk("tbl_imm", PW'(out_imm), PW'(tbl[i].imm));
    end
    set_in(0, '0, '0);
    tick();

    // back-to-back independent adds
    reset_dut();
    out_ready = 1;
    set_in(1, mk(2'd0, 4'b0010, 4'd1, 4'd2, 4'd3, 14'd0), 24'h100);
    tick();
    chk("b2b_rdy0", PW'(seen_rdy), PW'(1));
    chk("b2b_rc0", PW'(out_rc), PW'(1));
    set_in(1, mk(2'd0, 4'b0010, 4'd4, 4'd5, 4'd6, 14'd0), 24'h104);
    tick();
    chk("b2b_rdy1", PW'(seen_rdy), PW'(1));
    chk("b2b_valid1", PW'(out_valid), PW'(1));
    chk("b2b_rc1", PW'(out_rc), PW'(4));
    set_in(0, '0, '0);
    tick();
    chk("b2b_stall", PW'(stall_cnt), PW'(0));

    // scalar RAW: producer R1, consumer R2=R1+R3, writeback four cycles later
    reset_dut();
    out_ready = 1;
    acc_t = -1;
    for (int t = 0; t < 10; t++) begin
      if (t == 0)        set_in(1, mk(2'd0, 4'b0010, 4'd1, 4'd2, 4'd3, 14'd0), 24'h200);
      else if (acc_t < 0) set_in(1, mk(2'd0, 4'b0010, 4'd2, 4'd1, 4'd3, 14'd0), 24'h204);
      else               set_in(0, '0, '0);
      if (t == 4) set_wb(1, 0, 4'd1, 24'h5A5A5A, '0);
      else        set_wb(0, 0, '0, '0, '0);
      tick();
      if (t > 0 && acc_t < 0 && out_valid && out_rc == 4'd2) acc_t = t;
    end
`ifdef WB_BYPASS_EN
    chk("raw_issue_cycle", PW'(acc_t), PW'(4));
    chk("raw_stall", PW'(stall_cnt), PW'(3));
`else
    chk("raw_issue_cycle", PW'(acc_t), PW'(5));
    chk("raw_stall", PW'(stall_cnt), PW'(4));
`endif
    chk("raw_rd1", PW'(out_rd1), PW'(24'h5A5A5A));

    // vector producer V2 does not block scalar reader of R2
    reset_dut();
    out_ready = 1;
    set_in(1, mk(2'd2, 4'b0011, 4'd2, 4'd0, 4'd0, 14'd0), 24'h300);
    tick();
    set_in(1, mk(2'd0, 4'b0010, 4'd5, 4'd2, 4'd0, 14'd0), 24'h304);
    tick();
    chk("vs_rdy", PW'(seen_rdy), PW'(1));
    chk("vs_rc", PW'(out_rc), PW'(5));
    chk("vs_stall", PW'(stall_cnt), PW'(0));

    // backpressure: held instruction stays put, then leaves as the next enters
    reset_dut();
    out_ready = 0;
    set_in(1, mk(2'd0, 4'b0001, 4'd9, 4'd0, 4'd0, 14'd3), 24'h400);
    tick();
    chk("bp_rdy_first", PW'(seen_rdy), PW'(1));
    set_in(1, mk(2'd0, 4'b0001, 4'd10, 4'd0, 4'd0, 14'd4), 24'h404);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_rdy_held", PW'(seen_rdy), PW'(0));
      chk("bp_pc_held", PW'(out_pc), PW'(24'h400));
      chk("bp_valid_held", PW'(out_valid), PW'(1));
    end
    out_ready = 1;
    tick();
    chk("bp_rdy_release", PW'(seen_rdy), PW'(1));
    chk("bp_pc_next", PW'(out_pc), PW'(24'h404));

    // flush a writer of R7; reader of R7 then issues without stall
    reset_dut();
    out_ready = 0;
    set_in(1, mk(2'd0, 4'b0010, 4'd7, 4'd1, 4'd2, 14'd0), 24'h500);
    tick();
    chk("fl_valid_before", PW'(out_valid), PW'(1));
    set_in(0, '0, '0);
    flush = 1;
    tick();
    chk("fl_valid_after", PW'(out_valid), PW'(0));
    flush = 0;
    out_ready = 1;
    set_in(1, mk(2'd0, 4'b0010, 4'd8, 4'd7, 4'd0, 14'd0), 24'h504);
    tick();
    chk("fl_reader_rdy", PW'(seen_rdy), PW'(1));
    chk("fl_reader_pc", PW'(out_pc), PW'(24'h504));
    chk("fl_stall", PW'(stall_cnt), PW'(0));

    // reset mid-operation with a pending R3 and a nonzero bank entry
    reset_dut();
    out_ready = 0;
    set_in(1, mk(2'd0, 4'b0010, 4'd3, 4'd0, 4'd0, 14'd0), 24'h600);
    set_wb(1, 0, 4'd5, 24'hABCDEF, '0);
    tick();
    set_wb(0, 0, '0, '0, '0);
    set_in(1, mk(2'd0, 4'b0010, 4'd8, 4'd3, 4'd5, 14'd0), 24'h604);
    tick();
    chk("mr_stall_pre", PW'(stall_cnt), PW'(1));
    chk("mr_valid_pre", PW'(out_valid), PW'(1));
    reset_dut();
    out_ready = 1;
    set_in(1, mk(2'd0, 4'b0010, 4'd8, 4'd5, 4'd3, 14'd0), 24'h608);
    tick();
    chk("mr_rdy_after", PW'(seen_rdy), PW'(1));
    chk("mr_bank_cleared", PW'(out_rd1), PW'(0));

    // random traffic against the model
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      set_in(($urandom % 4) != 0, $urandom, 24'($urandom));
      flush = (($urandom % 16) == 0);
      out_ready = (($urandom % 4) != 0);
      rnd_v = {$urandom, $urandom, $urandom, $urandom, $urandom};
      set_wb(($urandom % 2) == 1, ($urandom % 2) == 1, 4'($urandom),
             24'($urandom), rnd_v[VW-1:0]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
